// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, reset/halt constants and FSM state type for the fetch stage.
package fetch_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;
    localparam logic [DATA_W-1:0] HALT_OPCODE = 8'hFF;
    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
endpackage

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, fetch FSM and registered IF/ID output with valid/ready handshake.
module instruction_fetch #(
    parameter int ADDR_W = fetch_pkg::ADDR_W,
    parameter int DATA_W = fetch_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = fetch_pkg::RESET_PC,
    parameter logic [DATA_W-1:0] HALT_OPCODE = fetch_pkg::HALT_OPCODE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] instruction_address,
    input  logic [DATA_W-1:0] instruction_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              halted
);
    import fetch_pkg::*;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, ipc_q, ipc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d, halted_q;
    logic              load_en, is_halt;

    assign load_en = !valid_q || if_ready;
    assign is_halt = instruction_data == HALT_OPCODE;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        case (state_q)
            IDLE: begin
                pc_d    = redirect_valid ? redirect_target : pc_q;
                state_d = start ? RUN : IDLE;
            end
            RUN: begin
                // redirect flushes the output even while decode is stalling
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    valid_d = 1'b0;
                end else if (load_en) begin
                    instr_d = instruction_data;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    pc_d    = is_halt ? pc_q : pc_q + ADDR_W'(1);
                    state_d = is_halt ? HALTED : RUN;
                end
            end
            HALTED: begin
                pc_d    = redirect_valid ? redirect_target : pc_q;
                valid_d = valid_q && !if_ready && !redirect_valid;
                state_d = redirect_valid ? RUN : HALTED;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            instr_q  <= '0;
            ipc_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            ipc_q    <= ipc_d;
            halted_q <= state_d == HALTED;
        end
    end

    assign instruction_address = pc_q;
    assign if_valid            = valid_q;
    assign if_instr            = instr_q;
    assign if_pc               = ipc_q;
    assign halted              = halted_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed test of instruction_fetch against a small combinational memory.
module tb_instruction_fetch;
    logic       clk = 1'b0;
    logic       rst_n, start, redirect_valid, if_ready;
    logic [7:0] redirect_target, instruction_address, instruction_data, if_instr, if_pc;
    logic       if_valid, halted;
    logic [7:0] mem [256];
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;
    assign instruction_data = mem[instruction_address];

    instruction_fetch dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .instruction_address(instruction_address), .instruction_data(instruction_data),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .halted(halted)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic out(input string tag, input logic v, input logic [7:0] ins, input logic [7:0] pc,
                       input logic [7:0] addr, input logic h);
        chk({tag, ".valid"}, {7'd0, if_valid}, {7'd0, v});
        if (v) chk({tag, ".instr"}, if_instr, ins);
        if (v) chk({tag, ".pc"}, if_pc, pc);
        chk({tag, ".addr"}, instruction_address, addr);
        chk({tag, ".halted"}, {7'd0, halted}, {7'd0, h});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'hFF;
        mem[8'hFE] = 8'h44; mem[8'hFF] = 8'h55;
        rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_target = 8'h00; if_ready = 1'b1;
        #3;
        out("reset", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("reset.instr", if_instr, 8'h00);
        chk("reset.pc", if_pc, 8'h00);
        rst_n = 1'b1;
        tick(); out("idle_nofetch", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        start = 1'b1;
        tick(); out("start", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        start = 1'b0;
        // stream to halt
        tick(); out("run0", 1'b1, 8'h11, 8'h00, 8'h01, 1'b0);
        tick(); out("run1", 1'b1, 8'h22, 8'h01, 8'h02, 1'b0);
        tick(); out("run2", 1'b1, 8'h33, 8'h02, 8'h03, 1'b0);
        tick(); out("run3_halt", 1'b1, 8'hFF, 8'h03, 8'h03, 1'b1);
        tick(); out("halt_drain", 1'b0, 8'h00, 8'h00, 8'h03, 1'b1);
        start = 1'b1;
        tick(); out("halt_start_ignored", 1'b0, 8'h00, 8'h00, 8'h03, 1'b1);
        start = 1'b0;
        redirect_valid = 1'b1; redirect_target = 8'h00;
        tick(); out("halt_redirect", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        redirect_valid = 1'b0;
        tick(); out("resume", 1'b1, 8'h11, 8'h00, 8'h01, 1'b0);
        // stall
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); out("stall", 1'b1, 8'h11, 8'h00, 8'h01, 1'b0);
        end
        if_ready = 1'b1;
        tick(); out("stall_release", 1'b1, 8'h22, 8'h01, 8'h02, 1'b0);
        // redirect beats stall
        if_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 8'h02;
        tick(); out("redir_flush", 1'b0, 8'h00, 8'h00, 8'h02, 1'b0);
        redirect_valid = 1'b0;
        tick(); out("redir_fetch", 1'b1, 8'h33, 8'h02, 8'h03, 1'b0);
        tick(); out("redir_hold", 1'b1, 8'h33, 8'h02, 8'h03, 1'b0);
        // wrap-around
        if_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 8'hFE;
        tick(); out("wrap_flush", 1'b0, 8'h00, 8'h00, 8'hFE, 1'b0);
        redirect_valid = 1'b0;
        tick(); out("wrap_fe", 1'b1, 8'h44, 8'hFE, 8'hFF, 1'b0);
        tick(); out("wrap_ff", 1'b1, 8'h55, 8'hFF, 8'h00, 1'b0);
        tick(); out("wrap_00", 1'b1, 8'h11, 8'h00, 8'h01, 1'b0);
        tick(); out("wrap_01", 1'b1, 8'h22, 8'h01, 8'h02, 1'b0);
        // asynchronous reset between edges
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        out("async_reset", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("async_reset.instr", if_instr, 8'h00);
        chk("async_reset.pc", if_pc, 8'h00);
        #2 rst_n = 1'b1;
        tick(); out("post_reset_idle0", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        tick(); out("post_reset_idle1", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        start = 1'b1;
        tick(); out("restart", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        start = 1'b0;
        tick(); out("restart_fetch", 1'b1, 8'h11, 8'h00, 8'h01, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
